// File: rtl/regfile_mp.sv
// regfile_mp: two-read/two-write register file with a per-register busy scoreboard and optional write forwarding.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [AW-1:0]     ReadReg1,
  input  logic [AW-1:0]     ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic [AW-1:0]     WriteReg0,
  input  logic [DATA_W-1:0] WriteData0,
  input  logic              RegWre0,
  input  logic [AW-1:0]     WriteReg1,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic              RegWre1,
  input  logic [AW-1:0]     SetBusyReg,
  input  logic              SetBusy
);
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic              we0, we1, fw0, fw1;
  assign we0 = RegWre0 && WriteReg0 != '0;
  assign we1 = RegWre1 && WriteReg1 != '0;
  assign fw0 = BYPASS != 0 && !RST && we0;
  assign fw1 = BYPASS != 0 && !RST && we1;
  // Port 1 is assigned last so it wins a same-address collision; the set is last so it beats a clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (we0) begin
        regs[WriteReg0] <= WriteData0;
        busy[WriteReg0] <= 1'b0;
      end
      if (we1) begin
        regs[WriteReg1] <= WriteData1;
        busy[WriteReg1] <= 1'b0;
      end
      if (SetBusy && SetBusyReg != '0) busy[SetBusyReg] <= 1'b1;
    end
  end
  assign ReadData1 = ReadReg1 == '0 ? '0
                   : fw1 && WriteReg1 == ReadReg1 ? WriteData1
                   : fw0 && WriteReg0 == ReadReg1 ? WriteData0
                   : regs[ReadReg1];
  assign ReadData2 = ReadReg2 == '0 ? '0
                   : fw1 && WriteReg1 == ReadReg2 ? WriteData1
                   : fw0 && WriteReg0 == ReadReg2 ? WriteData0
                   : regs[ReadReg2];
  assign ReadBusy1 = ReadReg1 != '0 && busy[ReadReg1];
  assign ReadBusy2 = ReadReg2 != '0 && busy[ReadReg2];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of a forwarding and a non-forwarding regfile_mp driven by shared stimulus.
module tb_regfile_mp;
  logic        CLK = 0, RST = 0;
  logic [4:0]  ReadReg1 = 0, ReadReg2 = 0, WriteReg0 = 0, WriteReg1 = 0, SetBusyReg = 0;
  logic [31:0] WriteData0 = 0, WriteData1 = 0;
  logic        RegWre0 = 0, RegWre1 = 0, SetBusy = 0;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        bz1_b, bz2_b, bz1_n, bz2_n;
  int          checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  regfile_mp #(.DATA_W(32), .NREGS(32), .BYPASS(1)) u_byp (
    .CLK(CLK), .RST(RST), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1_b), .ReadData2(rd2_b), .ReadBusy1(bz1_b), .ReadBusy2(bz2_b),
    .WriteReg0(WriteReg0), .WriteData0(WriteData0), .RegWre0(RegWre0),
    .WriteReg1(WriteReg1), .WriteData1(WriteData1), .RegWre1(RegWre1),
    .SetBusyReg(SetBusyReg), .SetBusy(SetBusy));

  regfile_mp #(.DATA_W(32), .NREGS(32), .BYPASS(0)) u_nob (
    .CLK(CLK), .RST(RST), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1_n), .ReadData2(rd2_n), .ReadBusy1(bz1_n), .ReadBusy2(bz2_n),
    .WriteReg0(WriteReg0), .WriteData0(WriteData0), .RegWre0(RegWre0),
    .WriteReg1(WriteReg1), .WriteData1(WriteData1), .RegWre1(RegWre1),
    .SetBusyReg(SetBusyReg), .SetBusy(SetBusy));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 0; RegWre0 = 0; RegWre1 = 0; SetBusy = 0;
    WriteReg0 = 0; WriteReg1 = 0; SetBusyReg = 0; WriteData0 = 0; WriteData1 = 0;
  endtask

  task automatic test_reset();
    idle();
    RST = 1;
    tick();
    idle();
    for (int a = 0; a < 32; a++) begin
      ReadReg1 = a[4:0];
      #1;
      checks++;
      if (rd1_b !== 32'h0 || bz1_b !== 1'b0 || rd1_n !== 32'h0 || bz1_n !== 1'b0) begin
        errors++;
        $display("FAIL reset_sweep reg %0d got data %h/%h busy %b/%b exp 0/0 busy 0", a, rd1_b, rd1_n, bz1_b, bz1_n);
      end
    end
  endtask

  task automatic test_collision();
    RegWre0 = 1; RegWre1 = 1; WriteReg0 = 5; WriteReg1 = 5;
    WriteData0 = 32'h11111111; WriteData1 = 32'h22222222; ReadReg1 = 5; ReadReg2 = 5;
    #1;
    checks++;
    if (rd1_b !== 32'h22222222) begin errors++; $display("FAIL collision_bypass got %h exp 22222222", rd1_b); end
    checks++;
    if (rd2_n !== 32'h0) begin errors++; $display("FAIL collision_nobypass_same got %h exp 00000000", rd2_n); end
    tick();
    idle();
    #1;
    checks++;
    if (rd1_b !== 32'h22222222 || rd1_n !== 32'h22222222) begin
      errors++; $display("FAIL collision_next got %h/%h exp 22222222", rd1_b, rd1_n);
    end
  endtask

  task automatic test_reg0();
    RegWre0 = 1; WriteReg0 = 0; WriteData0 = 32'hDEADBEEF; SetBusy = 1; SetBusyReg = 0; ReadReg1 = 0;
    #1;
    checks++;
    if (rd1_b !== 32'h0 || bz1_b !== 1'b0) begin errors++; $display("FAIL reg0_same got %h busy %b exp 0 busy 0", rd1_b, bz1_b); end
    tick();
    idle();
    #1;
    checks++;
    if (rd1_b !== 32'h0 || bz1_b !== 1'b0 || rd1_n !== 32'h0) begin
      errors++; $display("FAIL reg0_next got %h/%h busy %b exp 0 busy 0", rd1_b, rd1_n, bz1_b);
    end
  endtask

  task automatic test_race();
    ReadReg1 = 7; ReadReg2 = 7;
    SetBusy = 1; SetBusyReg = 7;
    tick();
    idle();
    #1;
    checks++;
    if (bz1_b !== 1'b1) begin errors++; $display("FAIL race_set got busy %b exp 1", bz1_b); end
    RegWre0 = 1; WriteReg0 = 7; WriteData0 = 32'h00000077; SetBusy = 1; SetBusyReg = 7;
    tick();
    idle();
    #1;
    checks++;
    if (bz2_b !== 1'b1 || rd1_b !== 32'h00000077) begin
      errors++; $display("FAIL race_setwins got busy %b data %h exp busy 1 data 00000077", bz2_b, rd1_b);
    end
    RegWre1 = 1; WriteReg1 = 7; WriteData1 = 32'h00007777;
    #1;
    checks++;
    if (bz1_b !== 1'b1) begin errors++; $display("FAIL race_clear_same got busy %b exp 1", bz1_b); end
    tick();
    idle();
    #1;
    checks++;
    if (bz1_b !== 1'b0 || bz2_n !== 1'b0 || rd1_b !== 32'h00007777) begin
      errors++; $display("FAIL race_clear got busy %b/%b data %h exp busy 0 data 00007777", bz1_b, bz2_n, rd1_b);
    end
  endtask

  task automatic test_independent();
    SetBusy = 1; SetBusyReg = 1;
    tick();
    SetBusyReg = 2;
    tick();
    idle();
    RegWre0 = 1; WriteReg0 = 1; WriteData0 = 32'hAAAA0001;
    RegWre1 = 1; WriteReg1 = 2; WriteData1 = 32'hBBBB0002;
    SetBusy = 1; SetBusyReg = 3;
    tick();
    idle();
    ReadReg1 = 1; ReadReg2 = 2;
    #1;
    checks++;
    if (bz1_b !== 1'b0 || bz2_b !== 1'b0 || rd1_b !== 32'hAAAA0001 || rd2_b !== 32'hBBBB0002) begin
      errors++; $display("FAIL indep_clears got busy %b%b data %h %h exp busy 00 data aaaa0001 bbbb0002", bz1_b, bz2_b, rd1_b, rd2_b);
    end
    ReadReg1 = 3;
    #1;
    checks++;
    if (bz1_b !== 1'b1 || rd1_b !== 32'h0) begin errors++; $display("FAIL indep_set got busy %b data %h exp busy 1 data 0", bz1_b, rd1_b); end
  endtask

  task automatic test_bypass_off();
    RegWre0 = 1; WriteReg0 = 3; WriteData0 = 32'hA5A5A5A5; ReadReg1 = 3;
    #1;
    checks++;
    if (rd1_n !== 32'h0) begin errors++; $display("FAIL nobypass_same got %h exp 00000000", rd1_n); end
    checks++;
    if (rd1_b !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_same got %h exp a5a5a5a5", rd1_b); end
    tick();
    idle();
    #1;
    checks++;
    if (rd1_n !== 32'hA5A5A5A5) begin errors++; $display("FAIL nobypass_next got %h exp a5a5a5a5", rd1_n); end
  endtask

  task automatic test_reset_mid();
    for (int r = 1; r <= 4; r++) begin
      RegWre0 = 1; WriteReg0 = r[4:0]; WriteData0 = r * 32'h100; SetBusy = 1; SetBusyReg = r[4:0];
      tick();
    end
    idle();
    ReadReg1 = 2;
    #1;
    checks++;
    if (bz1_b !== 1'b1 || rd1_b !== 32'h200) begin errors++; $display("FAIL mid_pre got busy %b data %h exp busy 1 data 00000200", bz1_b, rd1_b); end
    RST = 1; RegWre0 = 1; WriteReg0 = 2; WriteData0 = 32'h00000BAD; SetBusy = 1; SetBusyReg = 6;
    #1;
    checks++;
    if (rd1_b !== 32'h200) begin errors++; $display("FAIL mid_no_bypass_in_reset got %h exp 00000200", rd1_b); end
    tick();
    idle();
    for (int a = 0; a <= 6; a++) begin
      ReadReg1 = a[4:0]; ReadReg2 = a[4:0];
      #1;
      checks++;
      if (rd1_b !== 32'h0 || bz1_b !== 1'b0 || rd2_n !== 32'h0 || bz2_n !== 1'b0) begin
        errors++; $display("FAIL mid_cleared reg %0d got data %h/%h busy %b/%b exp 0 busy 0", a, rd1_b, rd2_n, bz1_b, bz2_n);
      end
    end
    RegWre1 = 1; WriteReg1 = 4; WriteData1 = 32'h44444444;
    tick();
    idle();
    ReadReg1 = 4;
    #1;
    checks++;
    if (rd1_n !== 32'h44444444) begin errors++; $display("FAIL post_reset_write got %h exp 44444444", rd1_n); end
  endtask

  initial begin
    #2;
    test_reset();
    test_collision();
    test_reg0();
    test_race();
    test_independent();
    test_bypass_off();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
